led_pattern_sequencer: RTL and testbench

//  Avalon-MM controller that sequences the LED parallel-output port autonomously.
//  - The CPU configures it through a 4-word slave: mode, step period and seed pattern.
//  - Its master port then writes a new pattern to the LED PIO (register 0) each period.
//  - Sits between the Nios system interconnect and the LED PIO slave, and offloads LED animation from software.

---
 rtl/led_seq_pkg.sv | 27 ++
 rtl/led_seq_next.sv | 48 ++++
 rtl/led_pattern_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: slave register map,
// animation modes and controller states.
package led_seq_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_SEED   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STATUS_RUN_BIT = 16;
  localparam int STATUS_DIR_BIT = 17;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTL   = 2'd1,
    MODE_ROTR   = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PUSH,
    RUN
  } state_e;

endpackage

// File: rtl/led_seq_next.sv
// Combinational step function: computes the next LED pattern and bounce
// direction from the current pattern, animation mode and direction.
module led_seq_next
  import led_seq_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic [LED_W-1:0] pattern_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  output logic [LED_W-1:0] pattern_o,
  output logic             dir_o
);

  mode_e            mode;
  logic [LED_W-1:0] shl;
  logic [LED_W-1:0] shr;
  logic             fwd_blocked;
  logic             rev_blocked;

  assign mode = mode_e'(mode_i);
  assign shl  = pattern_i << 1;
  assign shr  = pattern_i >> 1;

  // Shifting the way we face is blocked when the leading edge bit is lit.
  assign fwd_blocked = dir_i ? pattern_i[LED_W-1] : pattern_i[0];
  assign rev_blocked = dir_i ? pattern_i[0] : pattern_i[LED_W-1];

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed path would infer a latch.
    pattern_o = pattern_i;
    dir_o     = dir_i;
    case (mode)
      MODE_ROTL: pattern_o = {pattern_i[LED_W-2:0], pattern_i[LED_W-1]};
      MODE_ROTR: pattern_o = {pattern_i[0], pattern_i[LED_W-1:1]};
      MODE_BOUNCE: begin
        if (!fwd_blocked) begin
          pattern_o = dir_i ? shl : shr;
        end else begin
          dir_o = ~dir_i;
          if (!rev_blocked) pattern_o = dir_i ? shr : shl;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED animation controller: CPU-facing config slave plus a master
// that pushes a fresh pattern into LED PIO register 0 once per step period.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int PERIOD_W   = 24,
  parameter int PERIOD_RST = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [1:0]  m_address,
  output logic [31:0] m_writedata
);

  logic                en_q;
  mode_e               mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [LED_W-1:0]    seed_q;

  state_e              state_q, state_d;
  logic [LED_W-1:0]    pattern_q, pattern_d;
  logic                dir_q, dir_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  logic [LED_W-1:0]    step_pattern;
  logic                step_dir;
  logic                wr_en, wr_ctrl, wr_period, wr_seed;
  logic                running, restart, stop, step_due;
  logic [PERIOD_W-1:0] period_last;
  logic                unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_period = wr_en && (address == ADDR_PERIOD);
  assign wr_seed   = wr_en && (address == ADDR_SEED);
  assign running   = (state_q != IDLE);
  assign restart   = (wr_ctrl && writedata[0]) || (wr_seed && running);
  assign stop      = wr_ctrl && !writedata[0];

  // PERIOD = 0 behaves as 1; >= lets a shortened period fire on the next cycle.
  assign period_last = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign step_due    = (cnt_q >= period_last);

  assign unused_wdata = ^writedata[31:PERIOD_W];

  led_seq_next #(.LED_W(LED_W)) u_next (
    .pattern_i (pattern_q),
    .mode_i    (mode_q),
    .dir_i     (dir_q),
    .pattern_o (step_pattern),
    .dir_o     (step_dir)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (!reset_n) begin
      en_q      <= 1'b0;
      mode_q    <= MODE_STATIC;
      period_q  <= PERIOD_W'(PERIOD_RST);
      seed_q    <= '0;
      state_q   <= IDLE;
      pattern_q <= '0;
      dir_q     <= 1'b1;
      cnt_q     <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q   <= writedata[0];
        mode_q <= mode_e'(writedata[2:1]);
      end
      if (wr_period) period_q <= writedata[PERIOD_W-1:0];
      if (wr_seed)   seed_q   <= writedata[LED_W-1:0];
      state_q   <= state_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (en_q) state_d = LOAD;
      LOAD: begin
        pattern_d = seed_q;
        dir_d     = 1'b1;
        state_d   = PUSH;
      end
      PUSH: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (step_due) begin
          pattern_d = step_pattern;
          dir_d     = step_dir;
          state_d   = PUSH;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // CPU commands override any step or load falling in the same cycle.
    if (stop || restart) begin
      pattern_d = pattern_q;
      dir_d     = dir_q;
      state_d   = stop ? IDLE : LOAD;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[2:0] = {mode_q, en_q};
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      ADDR_SEED:   readdata[LED_W-1:0] = seed_q;
      default: begin
        readdata[LED_W-1:0]     = pattern_q;
        readdata[STATUS_RUN_BIT] = running;
        readdata[STATUS_DIR_BIT] = dir_q;
      end
    endcase
  end

  assign m_chipselect = (state_q == PUSH);
  assign m_write_n    = (state_q != PUSH);
  assign m_address    = 2'b00;
  assign m_writedata  = {{(32 - LED_W){1'b0}}, pattern_q};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: register vectors, directed animation
// sequences, then random bus traffic against a timing-based reference model.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        m_chipselect;
  logic        m_write_n;
  logic [1:0]  m_address;
  logic [31:0] m_writedata;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.LED_W(8), .PERIOD_W(24), .PERIOD_RST(50000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_address    (m_address),
    .m_writedata  (m_writedata)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: registers plus event times (next push, pending load, last push).
  bit          mdl_valid = 1'b0;
  bit          mdl_en;
  logic [1:0]  mdl_mode;
  logic [23:0] mdl_period;
  logic [7:0]  mdl_seed;
  logic [7:0]  mdl_pat;
  bit          mdl_dir;
  bit          mdl_active;
  int          push_at, load_at, last_push;
  bit          counting;

  int          seen_pat[$];
  int          seen_cyc[$];
  logic [31:0] rd_sample, wd_sample;
  logic        cs_sample;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void step_model(input int p, input int mode, input bit d,
                                     output int np, output bit nd);
    bit fwd_free, rev_free;
    np = p;
    nd = d;
    fwd_free = d ? (p < 128) : (p % 2 == 0);
    rev_free = d ? (p % 2 == 0) : (p < 128);
    case (mode)
      1: np = (p * 2) % 256 + p / 128;
      2: np = p / 2 + (p % 2) * 128;
      3: begin
        if (fwd_free) np = d ? p * 2 : p / 2;
        else begin
          nd = !d;
          if (rev_free) np = d ? p / 2 : p * 2;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [35:0] exp_bus();
    bit p;
    p = (push_at == cyc);
    return {p, !p, 2'b00, 24'd0, mdl_pat};
  endfunction

  function automatic logic [31:0] mdl_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, mdl_mode, mdl_en};
      2'd1:    return {8'd0, mdl_period};
      2'd2:    return {24'd0, mdl_seed};
      default: return {14'd0, mdl_dir, mdl_active, 8'd0, mdl_pat};
    endcase
  endfunction

  task automatic model_reset();
    mdl_en = 0; mdl_mode = 0; mdl_period = 24'd50000; mdl_seed = 0;
    mdl_pat = 0; mdl_dir = 1; mdl_active = 0;
    push_at = -1; load_at = -1; last_push = -1; counting = 0;
  endtask

  task automatic model_edge(input bit rst_v, input bit wr, input logic [1:0] a, input logic [31:0] d);
    logic [7:0] p0;
    bit d0;
    int eff, np;
    bit nd;
    if (!rst_v) begin
      model_reset();
      return;
    end
    p0 = mdl_pat;
    d0 = mdl_dir;
    eff = (mdl_period == 0) ? 1 : int'(mdl_period);
    if (push_at == cyc) begin
      last_push = cyc; push_at = -1; counting = 1;
    end else if (counting && (cyc - last_push - 1) >= eff - 1) begin
      step_model(int'(mdl_pat), int'(mdl_mode), mdl_dir, np, nd);
      mdl_pat = 8'(np); mdl_dir = nd; push_at = cyc + 1; counting = 0;
    end
    if (load_at == cyc) begin
      mdl_pat = mdl_seed; mdl_dir = 1; load_at = -1;
    end
    if (wr && a == 2'd0 && !d[0]) begin
      mdl_active = 0; push_at = -1; load_at = -1; counting = 0;
      mdl_pat = p0; mdl_dir = d0;
    end else if (wr && (a == 2'd0 || (a == 2'd2 && mdl_active))) begin
      mdl_active = 1; push_at = cyc + 2; load_at = cyc + 1; counting = 0;
      mdl_pat = p0; mdl_dir = d0;
    end
    if (wr) begin
      case (a)
        2'd0: begin mdl_en = d[0]; mdl_mode = d[2:1]; end
        2'd1: mdl_period = d[23:0];
        2'd2: mdl_seed = d[7:0];
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mdl_valid) begin
      check("bus", {m_chipselect, m_write_n, m_address, m_writedata}, exp_bus());
      check("readdata", readdata, mdl_read(address));
    end
    rd_sample = readdata;
    wd_sample = m_writedata;
    cs_sample = m_chipselect;
    if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
      seen_pat.push_back(int'(m_writedata[7:0]));
      seen_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_edge(reset_n, chipselect & ~write_n, address, writedata);
    if (!reset_n) mdl_valid = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0; write_n = 1'b1; address = 2'd3; writedata = '0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    bus_idle();
  endtask

  task automatic clear_seen();
    seen_pat.delete();
    seen_cyc.delete();
  endtask

  task automatic stop_run();
    wr_reg(2'd0, 32'd0);
    repeat (3) tick();
    clear_seen();
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } reg_vec_t;

  reg_vec_t vecs[9];
  int       k;
  int       r;
  int       exp3[11];

  initial begin
    vecs[0] = '{2'd1, 32'h0000_0007, 32'h0000_0007};
    vecs[1] = '{2'd1, 32'hFF12_3456, 32'h0012_3456};
    vecs[2] = '{2'd2, 32'hFFFF_FFA5, 32'h0000_00A5};
    vecs[3] = '{2'd0, 32'hFFFF_FFF6, 32'h0000_0006};
    vecs[4] = '{2'd0, 32'h0000_0004, 32'h0000_0004};
    vecs[5] = '{2'd3, 32'hFFFF_FFFF, 32'h0002_0000};
    vecs[6] = '{2'd1, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
    exp3 = '{'h18, 'h30, 'h60, 'hC0, 'h60, 'h30, 'h18, 'h0C, 'h06, 'h03, 'h06};

    reset_n = 1'b0;
    bus_idle();
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    address = 2'd1;
    tick();
    check("reset_period", rd_sample, 32'd50000);
    check("reset_cs", cs_sample, 1'b0);
    address = 2'd3;
    tick();
    check("reset_status", {rd_sample[16], rd_sample[7:0]}, 9'd0);

    // Register map vectors while idle
    for (int i = 0; i < 9; i++) begin
      wr_reg(vecs[i].addr, vecs[i].wdata);
      address = vecs[i].addr;
      tick();
      check("regvec", rd_sample, vecs[i].exp_rd);
    end
    bus_idle();
    clear_seen();

    // ROTL from 0x01, P = 3
    wr_reg(2'd2, 32'h01);
    wr_reg(2'd1, 32'd3);
    k = cyc;
    wr_reg(2'd0, 32'h3);
    repeat (45) tick();
    check("rotl_count_ok", seen_pat.size() >= 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("rotl_pat", (i < seen_pat.size()) ? seen_pat[i] : -1, (8'h01 << (i % 8)));
      check("rotl_time", (i < seen_cyc.size()) ? seen_cyc[i] : -1, k + 2 + 4 * i);
    end
    stop_run();

    // BOUNCE with both edges lit holds, then a bouncing seed
    wr_reg(2'd2, 32'h81);
    wr_reg(2'd1, 32'd1);
    k = cyc;
    wr_reg(2'd0, 32'h7);
    repeat (12) tick();
    for (int i = 0; i < 5; i++) begin
      check("bounce81_pat", (i < seen_pat.size()) ? seen_pat[i] : -1, 32'h81);
      check("bounce81_time", (i < seen_cyc.size()) ? seen_cyc[i] : -1, k + 2 + 2 * i);
    end
    k = cyc;
    wr_reg(2'd2, 32'h18);
    clear_seen();
    repeat (30) tick();
    for (int i = 0; i < 11; i++) begin
      check("bounce18_pat", (i < seen_pat.size()) ? seen_pat[i] : -1, exp3[i]);
    end
    check("bounce18_first", (seen_cyc.size() > 0) ? seen_cyc[0] : -1, k + 2);
    stop_run();

    // ROTR, P = 10, disable while counter is at 5
    wr_reg(2'd2, 32'h01);
    wr_reg(2'd1, 32'd10);
    k = cyc;
    wr_reg(2'd0, 32'h5);
    while (cyc < k + 19) tick();
    check("rotr_second", (seen_pat.size() > 1) ? seen_pat[1] : -1, 32'h80);
    wr_reg(2'd0, 32'h0);
    clear_seen();
    tick();
    check("stop_running", rd_sample[16], 1'b0);
    check("stop_pattern", rd_sample[7:0], 8'h80);
    repeat (30) tick();
    check("stop_no_writes", seen_pat.size(), 0);
    check("stop_led_holds", wd_sample, 32'h80);
    clear_seen();

    // SEED write on the step cycle discards the step
    wr_reg(2'd2, 32'h01);
    wr_reg(2'd1, 32'd3);
    k = cyc;
    wr_reg(2'd0, 32'h3);
    while (cyc < k + 5) tick();
    wr_reg(2'd2, 32'h55);
    clear_seen();
    repeat (10) tick();
    check("seed_restart_pat", (seen_pat.size() > 0) ? seen_pat[0] : -1, 32'h55);
    check("seed_restart_time", (seen_cyc.size() > 0) ? seen_cyc[0] : -1, k + 7);
    stop_run();

    // Reset during a PIO write
    k = cyc;
    wr_reg(2'd0, 32'h3);
    while (cyc < k + 2) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_was_push", cs_sample, 1'b1);
    tick();
    check("rst_cs_low", cs_sample, 1'b0);
    clear_seen();
    repeat (20) tick();
    check("rst_no_writes", seen_pat.size(), 0);
    k = cyc;
    wr_reg(2'd0, 32'h3);
    repeat (4) tick();
    check("rst_rearm_time", (seen_cyc.size() > 0) ? seen_cyc[0] : -1, k + 2);
    check("rst_rearm_pat", (seen_pat.size() > 0) ? seen_pat[0] : -1, 0);
    stop_run();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      reset_n = ($urandom_range(0, 399) != 0);
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      if (r < 14) begin
        chipselect = 1'b1;
        write_n = 1'b0;
        if (address == 2'd1)
          writedata = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
        if (address == 2'd0) writedata[0] = ($urandom_range(0, 3) != 0);
      end else if (r < 18) begin
        chipselect = 1'b0;
        write_n = 1'b0;
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n = 1'b1;
      end
      tick();
    end
    reset_n = 1'b1;
    bus_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
